// File: rtl/alu_top.sv
// alu_top: 32-bit ALU board demonstrator.
// Switch-selected operand presets feed a combinational ALU; one result byte
// (or the flag byte) is chosen for display and registered onto the LEDs.
module alu_top (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] ALU_OP,
  input  logic [2:0] AB_SW,
  input  logic [2:0] F_LED_SW,
  output logic [7:0] LED
);

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_NOR = 3'b011,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101,
    OP_SLT = 3'b110,
    OP_SLL = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } operands_t;

  typedef struct packed {
    logic [31:0] f;
    logic        zf;
    logic        of;
  } alu_rsp_t;

  operands_t   opnd;
  alu_op_e     op;
  alu_rsp_t    rsp;
  logic [32:0] sum_ext;
  logic [32:0] diff_ext;
  logic [7:0]  led_d;
  logic [7:0]  led_q;

  assign op = alu_op_e'(ALU_OP);

  // Fixed operand-pair presets selected by the AB switches.
  always_comb begin
    opnd = '0;
    unique case (AB_SW)
      3'b000: begin opnd.a = 32'h0000_0000; opnd.b = 32'h0000_0000; end
      3'b001: begin opnd.a = 32'h0000_0003; opnd.b = 32'h0000_0607; end
      3'b010: begin opnd.a = 32'h8000_0000; opnd.b = 32'h8000_0000; end
      3'b011: begin opnd.a = 32'h7FFF_FFFF; opnd.b = 32'h7FFF_FFFF; end
      3'b100: begin opnd.a = 32'hFFFF_FFFF; opnd.b = 32'hFFFF_FFFF; end
      3'b101: begin opnd.a = 32'h8000_0000; opnd.b = 32'hFFFF_FFFF; end
      3'b110: begin opnd.a = 32'hFFFF_FFFF; opnd.b = 32'h8000_0000; end
      default: begin opnd.a = 32'h1234_5678; opnd.b = 32'h3333_3333; end
    endcase
  end

  // 33-bit arithmetic so carry-out and borrow fall out of the top bit.
  assign sum_ext  = {1'b0, opnd.a} + {1'b0, opnd.b};
  assign diff_ext = {1'b0, opnd.a} - {1'b0, opnd.b};

  // ALU result and flags; OF is only meaningful for ADD (carry) and SUB (borrow).
  always_comb begin
    rsp = '0;
    unique case (op)
      OP_AND: rsp.f = opnd.a & opnd.b;
      OP_OR:  rsp.f = opnd.a | opnd.b;
      OP_XOR: rsp.f = opnd.a ^ opnd.b;
      OP_NOR: rsp.f = ~(opnd.a | opnd.b);
      OP_ADD: begin
        rsp.f  = sum_ext[31:0];
        rsp.of = sum_ext[32];
      end
      OP_SUB: begin
        rsp.f  = diff_ext[31:0];
        rsp.of = diff_ext[32];
      end
      OP_SLT: rsp.f = {31'b0, ($signed(opnd.a) < $signed(opnd.b))};
      default: rsp.f = opnd.b << opnd.a[4:0];
    endcase
    rsp.zf = (rsp.f == 32'h0);
  end

  // Display mux: one result byte, or the flag byte with ZF on bit 7, OF on bit 0.
  always_comb begin
    led_d = 8'h00;
    if (F_LED_SW[2]) begin
      led_d = {rsp.zf, 6'b0, rsp.of};
    end else begin
      unique case (F_LED_SW[1:0])
        2'b00:   led_d = rsp.f[7:0];
        2'b01:   led_d = rsp.f[15:8];
        2'b10:   led_d = rsp.f[23:16];
        default: led_d = rsp.f[31:24];
      endcase
    end
  end

  // LED register: cleared asynchronously, loads the display value every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led_q <= 8'h00;
    else        led_q <= led_d;
  end

  assign LED = led_q;

endmodule

// File: tb/tb_alu_top.sv
// tb_alu_top: scoreboard bench for alu_top. The driver pushes the expected LED
// value for each issued switch setting; the monitor pops one per clock edge.
module tb_alu_top;

  logic       clk;
  logic       rst_n;
  logic [2:0] alu_op;
  logic [2:0] ab_sw;
  logic [2:0] f_led_sw;
  logic [7:0] led;

  int checks;
  int fails;
  logic [7:0] exp_q[$];

  alu_top dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ALU_OP   (alu_op),
    .AB_SW    (ab_sw),
    .F_LED_SW (f_led_sw),
    .LED      (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain 64-bit arithmetic over the preset table.
  function automatic logic [7:0] model(input logic [2:0] ab, input logic [2:0] op,
                                       input logic [2:0] sel);
    longint unsigned pa[8];
    longint unsigned pb[8];
    longint unsigned a, b, f, full;
    longint sa, sb;
    bit zf, of;
    pa = '{64'h00000000, 64'h00000003, 64'h80000000, 64'h7FFFFFFF,
           64'hFFFFFFFF, 64'h80000000, 64'hFFFFFFFF, 64'h12345678};
    pb = '{64'h00000000, 64'h00000607, 64'h80000000, 64'h7FFFFFFF,
           64'hFFFFFFFF, 64'hFFFFFFFF, 64'h80000000, 64'h33333333};
    a = pa[ab];
    b = pb[ab];
    sa = (a >= 64'h80000000) ? longint'(a) - 64'sh100000000 : longint'(a);
    sb = (b >= 64'h80000000) ? longint'(b) - 64'sh100000000 : longint'(b);
    of = 1'b0;
    full = 0;
    case (op)
      3'd0: f = a & b;
      3'd1: f = a | b;
      3'd2: f = a ^ b;
      3'd3: f = (~(a | b)) & 64'hFFFFFFFF;
      3'd4: begin full = a + b; f = full % 64'h100000000; of = (full >= 64'h100000000); end
      3'd5: begin f = (a + 64'h100000000 - b) % 64'h100000000; of = (a < b); end
      3'd6: f = (sa < sb) ? 1 : 0;
      default: f = (b * (64'd1 << (a % 32))) % 64'h100000000;
    endcase
    zf = (f == 0);
    if (sel >= 3'd4) return {zf, 6'b0, of};
    return 8'((f >> (8 * sel)) & 64'hFF);
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: LED got %h expected %h", name, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] ab, input logic [2:0] op, input logic [2:0] sel,
                       input logic [7:0] exp);
    @(negedge clk);
    ab_sw = ab; alu_op = op; f_led_sw = sel;
    exp_q.push_back(exp);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      fails++;
      checks++;
      $display("FAIL drain_timeout: queue depth %0d expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: LED presents a new value after every edge; compare against the queue head.
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("scoreboard", led, e);
      end
    end
  end

  typedef struct {
    logic [2:0] ab;
    logic [2:0] op;
    logic [2:0] sel;
    logic [7:0] exp;
  } vec_t;

  initial begin
    vec_t vecs[$];
    logic [2:0] rab, rop, rsel;
    checks = 0;
    fails  = 0;
    rst_n  = 1'b0;
    ab_sw = 3'd4; alu_op = 3'd4; f_led_sw = 3'd0;
    #3;
    check("reset_async", led, 8'h00);
    @(posedge clk); #1;
    check("reset_held", led, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with values taken straight from the operation rules.
    vecs = '{
      '{3'b000, 3'b000, 3'b100, 8'h80},
      '{3'b001, 3'b000, 3'b000, 8'h03},
      '{3'b001, 3'b001, 3'b001, 8'h06},
      '{3'b001, 3'b010, 3'b000, 8'h04},
      '{3'b001, 3'b011, 3'b000, 8'hF8},
      '{3'b100, 3'b100, 3'b000, 8'hFE},
      '{3'b100, 3'b100, 3'b011, 8'hFF},
      '{3'b100, 3'b100, 3'b100, 8'h01},
      '{3'b100, 3'b101, 3'b100, 8'h80},
      '{3'b110, 3'b110, 3'b000, 8'h00},
      '{3'b101, 3'b110, 3'b000, 8'h01},
      '{3'b001, 3'b111, 3'b000, 8'h38},
      '{3'b011, 3'b100, 3'b011, 8'hFF},
      '{3'b010, 3'b100, 3'b100, 8'h81}
    };
    foreach (vecs[i]) issue(vecs[i].ab, vecs[i].op, vecs[i].sel, vecs[i].exp);
    drain();

    // Reset mid-operation while LED holds a nonzero value.
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid_async", led, 8'h00);
    @(posedge clk); #1;
    check("reset_mid_held", led, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'b111, 3'b101, 3'b100, model(3'b111, 3'b101, 3'b100));

    // Randomized sweep against the reference model.
    for (int i = 0; i < 400; i++) begin
      rab  = 3'($urandom_range(0, 7));
      rop  = 3'($urandom_range(0, 7));
      rsel = 3'($urandom_range(0, 7));
      issue(rab, rop, rsel, model(rab, rop, rsel));
    end
    drain();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
